mano_uart: RTL and testbench

Serial terminal adapter for the Mano machine core. It converts an 8N1 asynchronous serial line into the core's character-input handshake (`io_inpr`/`io_fgi`/`io_fgiset`). It also serialises characters the core writes via OUT (`io_outr`/`io_fgo`/`io_fgoset`). It sits between the board's UART pins and the `main` module's I/O ports.

---
 rtl/mano_io_pkg.sv | 30 +++
 rtl/mano_uart_if.sv | 32 +++
 rtl/mano_uart_rx.sv | 132 +++++++++++++
 rtl/mano_uart.sv | 169 ++++++++++++++++
 tb/tb_mano_uart.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mano_io_pkg.sv
// -----------------------------------------------------------------------------
// mano_io_pkg
// Shared types and constants for the Mano machine serial terminal adapter.
//   char_t               : one 8-bit terminal character
//   rx_state_e/tx_state_e: IDLE/START/DATA/STOP states of the two serial FSMs
//   DEFAULT_CLKS_PER_BIT : clocks per serial bit (50 MHz / 115200 baud)
//   FRAME_BITS           : bits in an 8N1 frame (start + 8 data + stop)
// -----------------------------------------------------------------------------
package mano_io_pkg;

  typedef logic [7:0] char_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/mano_uart_if.sv
// -----------------------------------------------------------------------------
// mano_uart_if
// Bundle of the serial pins and the Mano core I/O handshake.
//   master : core/board side (drives io_rxd, io_fgi, io_outr, io_fgo)
//   slave  : adapter side    (drives io_txd, io_inpr, io_fgiset, io_fgoset,
//                              io_overrun, io_framerr)
// -----------------------------------------------------------------------------
interface mano_uart_if;
  import mano_io_pkg::*;

  logic  io_rxd;
  logic  io_txd;
  char_t io_inpr;
  logic  io_fgi;
  logic  io_fgiset;
  char_t io_outr;
  logic  io_fgo;
  logic  io_fgoset;
  logic  io_overrun;
  logic  io_framerr;

  modport master (
    output io_rxd, io_fgi, io_outr, io_fgo,
    input  io_txd, io_inpr, io_fgiset, io_fgoset, io_overrun, io_framerr
  );

  modport slave (
    input  io_rxd, io_fgi, io_outr, io_fgo,
    output io_txd, io_inpr, io_fgiset, io_fgoset, io_overrun, io_framerr
  );

endinterface

// File: rtl/mano_uart_rx.sv
// -----------------------------------------------------------------------------
// mano_uart_rx
// 8N1 receiver: 2-FF synchroniser, start/data/stop FSM, sticky framing flag.
//   io_clock  : system clock
//   io_reset  : asynchronous active-high reset
//   rxd_i     : raw serial line (idle high, asynchronous)
//   byte_o    : received byte (valid while valid_o is high)
//   valid_o   : high for the single cycle in which a good stop bit is sampled
//   framerr_o : sticky, set when a stop bit is sampled low
// par_clks_per_bit must be even and >= 4.
// -----------------------------------------------------------------------------
module mano_uart_rx
  import mano_io_pkg::*;
#(
  parameter int par_clks_per_bit = DEFAULT_CLKS_PER_BIT
) (
  input  logic  io_clock,
  input  logic  io_reset,
  input  logic  rxd_i,
  output char_t byte_o,
  output logic  valid_o,
  output logic  framerr_o
);

  localparam int CW = $clog2(par_clks_per_bit);
  localparam logic [CW-1:0] FULL_CNT = CW'(par_clks_per_bit - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(par_clks_per_bit / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Synchroniser plus one history stage for edge detection. All reset low so
  // a line held low across reset release cannot look like a falling edge.
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  char_t         shift_q, shift_d;
  logic          framerr_q;
  logic          ferr_set;
  logic          cnt_done;

  assign cnt_done = (cnt_q == '0);

  // State register and datapath registers
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      rxd_meta_q <= 1'b0;
      rxd_sync_q <= 1'b0;
      rxd_prev_q <= 1'b0;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      framerr_q  <= 1'b0;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      framerr_q  <= framerr_q | ferr_set;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d = RX_START;
          cnt_d   = HALF_CNT;   // land the following samples mid-bit
        end
      end
      RX_START: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rxd_sync_q) begin
          state_d = RX_IDLE;    // line already back high: a glitch
        end else begin
          state_d = RX_DATA;
          cnt_d   = FULL_CNT;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {rxd_sync_q, shift_q[7:1]};  // LSB arrives first
          cnt_d   = FULL_CNT;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = RX_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: decide the frame outcome at the stop sample
  always_comb begin
    valid_o  = 1'b0;
    ferr_set = 1'b0;
    if (state_q == RX_STOP && cnt_done) begin
      if (rxd_sync_q) begin
        valid_o = 1'b1;
      end else begin
        ferr_set = 1'b1;
      end
    end
  end

  assign byte_o    = shift_q;
  assign framerr_o = framerr_q;

endmodule

// File: rtl/mano_uart.sv
// -----------------------------------------------------------------------------
// mano_uart
// Serial terminal adapter for the Mano machine core.
//   io_clock : system clock shared with the core
//   io_reset : asynchronous active-high reset
//   bus      : mano_uart_if.slave
//     io_rxd/io_txd       serial pins (idle high)
//     io_inpr/io_fgi/io_fgiset  character input handshake
//     io_outr/io_fgo/io_fgoset  character output handshake
//     io_overrun/io_framerr     sticky receive error flags
// A received byte is offered to the core only while io_fgi is clear; the
// transmitter starts on a 1->0 transition of io_fgo and ignores further
// transitions until its frame is complete.
// par_clks_per_bit must be even and >= 4.
// -----------------------------------------------------------------------------
module mano_uart
  import mano_io_pkg::*;
#(
  parameter int par_clks_per_bit = DEFAULT_CLKS_PER_BIT
) (
  input logic        io_clock,
  input logic        io_reset,
  mano_uart_if.slave bus
);

  localparam int CW = $clog2(par_clks_per_bit);
  localparam logic [CW-1:0] FULL_CNT = CW'(par_clks_per_bit - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // ---------------------------------------------------------------- receive
  char_t rx_byte;
  logic  rx_valid;
  logic  rx_framerr;

  mano_uart_rx #(
    .par_clks_per_bit(par_clks_per_bit)
  ) u_rx (
    .io_clock (io_clock),
    .io_reset (io_reset),
    .rxd_i    (bus.io_rxd),
    .byte_o   (rx_byte),
    .valid_o  (rx_valid),
    .framerr_o(rx_framerr)
  );

  char_t inpr_q;
  logic  fgiset_q;
  logic  overrun_q;

  // Core still holds the previous character: drop the new one and flag it.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      inpr_q    <= '0;
      fgiset_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fgiset_q <= 1'b0;
      if (rx_valid) begin
        if (bus.io_fgi) begin
          overrun_q <= 1'b1;
        end else begin
          inpr_q   <= rx_byte;
          fgiset_q <= 1'b1;
        end
      end
    end
  end

  assign bus.io_inpr    = inpr_q;
  assign bus.io_fgiset  = fgiset_q;
  assign bus.io_overrun = overrun_q;
  assign bus.io_framerr = rx_framerr;

  // --------------------------------------------------------------- transmit
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  char_t         tx_shift_q, tx_shift_d;
  logic          fgo_prev_q;
  logic          txd_q, txd_d;
  logic          tx_trigger;
  logic          tx_cnt_done;

  // History resets to 1 so a core that comes out of reset with io_fgo low
  // still produces exactly one frame.
  assign tx_trigger  = fgo_prev_q & ~bus.io_fgo;
  assign tx_cnt_done = (tx_cnt_q == '0);

  // State register and datapath registers
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      fgo_prev_q <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      fgo_prev_q <= bus.io_fgo;
      txd_q      <= txd_d;
    end
  end

  // Next-state logic
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_trigger) begin
          tx_state_d = TX_START;
          tx_cnt_d   = FULL_CNT;
          tx_shift_d = bus.io_outr;
        end
      end
      TX_START: begin
        if (!tx_cnt_done) begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = FULL_CNT;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (!tx_cnt_done) begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
          tx_cnt_d   = FULL_CNT;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (!tx_cnt_done) begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Outputs: the line level is computed from the next state and registered,
  // so the pin never glitches between bits.
  always_comb begin
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  assign bus.io_txd    = txd_q;
  assign bus.io_fgoset = (tx_state_q == TX_STOP) && tx_cnt_done;

endmodule

// File: tb/tb_mano_uart.sv
module tb_mano_uart;
  import mano_io_pkg::*;

  localparam int CPB       = 16;
  localparam int FRAME_CYC = CPB * FRAME_BITS;

  typedef struct {
    logic [7:0]  data;
    int unsigned start;
  } tx_exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int          total;
  int          bad;
  logic [7:0]  rx_exp[$];
  tx_exp_t     tx_exp[$];
  logic        ovr_model;
  logic        ferr_model;
  int          fgoset_seen;
  int          fgoset_exp;
  logic [7:0]  rx_want;

  mano_uart_if bus();

  mano_uart #(.par_clks_per_bit(CPB)) dut (
    .io_clock(clk),
    .io_reset(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_txd"},     32'(bus.io_txd),     32'd1);
    check({tag, "_inpr"},    32'(bus.io_inpr),    32'd0);
    check({tag, "_fgiset"},  32'(bus.io_fgiset),  32'd0);
    check({tag, "_fgoset"},  32'(bus.io_fgoset),  32'd0);
    check({tag, "_overrun"}, 32'(bus.io_overrun), 32'd0);
    check({tag, "_framerr"}, 32'(bus.io_framerr), 32'd0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_overrun"}, 32'(bus.io_overrun), 32'(ovr_model));
    check({tag, "_framerr"}, 32'(bus.io_framerr), 32'(ferr_model));
  endtask

  // Reference behaviour of a frame: bad stop -> framing error; good stop with
  // the core busy -> overrun; otherwise the core gets the byte.
  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    if (!stop_bit)       ferr_model = 1'b1;
    else if (bus.io_fgi) ovr_model  = 1'b1;
    else                 rx_exp.push_back(d);
    for (int i = 0; i < FRAME_BITS; i++) begin
      @(negedge clk);
      bus.io_rxd = fr[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.io_rxd = 1'b1;
    $display("rx frame data=%02h stop=%0b fgi=%0b", d, stop_bit, bus.io_fgi);
  endtask

  task automatic send_tx(input logic [7:0] d);
    tx_exp_t e;
    @(negedge clk);
    bus.io_outr = d;
    bus.io_fgo  = 1'b0;
    e.data  = d;
    e.start = cyc + 1;
    tx_exp.push_back(e);
    fgoset_exp++;
    @(negedge clk);
    bus.io_fgo = 1'b1;
    $display("tx trigger data=%02h", d);
  endtask

  // RX monitor: every io_fgiset pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.io_fgiset === 1'b1) begin
      total++;
      if (rx_exp.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected: fgiset with inpr=%02h, required no pulse", bus.io_inpr);
      end else begin
        rx_want = rx_exp.pop_front();
        if (bus.io_inpr !== rx_want) begin
          bad++;
          $display("FAIL rx_data: inpr=%02h required %02h", bus.io_inpr, rx_want);
        end
      end
    end
  end

  // TX monitor: decode each frame cycle by cycle against the expected bits.
  initial begin : tx_mon
    tx_exp_t    e;
    logic [9:0] fr;
    logic [9:0] cell_bad;
    logic [9:0] cell_act;
    logic       have;
    logic       aborted;
    int         fhits;
    int         fpos;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        // reset: nothing to decode
      end else if (bus.io_fgoset === 1'b1 && bus.io_txd !== 1'b0) begin
        fgoset_seen++;
        total++;
        bad++;
        $display("FAIL tx_stray_fgoset: fgoset=1 outside a frame at cycle %0d, required 0", cyc);
      end else if (bus.io_txd === 1'b0) begin
        have = (tx_exp.size() != 0);
        total++;
        fr = 10'h3ff;
        e.data = 8'h00;
        if (!have) begin
          bad++;
          $display("FAIL tx_unexpected: frame start at cycle %0d, required no frame", cyc);
        end else begin
          e = tx_exp.pop_front();
          fr = {1'b1, e.data, 1'b0};
          if (cyc != e.start) begin
            bad++;
            $display("FAIL tx_start: txd fell at cycle %0d, required %0d", cyc, e.start);
          end
        end
        aborted  = 1'b0;
        cell_bad = '0;
        cell_act = '0;
        fhits    = 0;
        fpos     = -1;
        for (int i = 0; i < FRAME_CYC; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (bus.io_txd !== fr[i / CPB]) begin
            if (!cell_bad[i / CPB]) cell_act[i / CPB] = bus.io_txd;
            cell_bad[i / CPB] = 1'b1;
          end
          if (bus.io_fgoset === 1'b1) begin
            fhits++;
            fpos = i;
            fgoset_seen++;
          end
        end
        if (!aborted && have) begin
          for (int k = 0; k < FRAME_BITS; k++) begin
            total++;
            if (cell_bad[k]) begin
              bad++;
              $display("FAIL tx_bit%0d: txd=%0b required %0b (data %02h)", k, cell_act[k], fr[k], e.data);
            end
          end
          total++;
          if (fhits != 1 || fpos != FRAME_CYC - 1) begin
            bad++;
            $display("FAIL tx_fgoset: %0d pulses, last at frame cycle %0d, required 1 at %0d",
                     fhits, fpos, FRAME_CYC - 1);
          end
          $display("tx frame data=%02h decoded", e.data);
        end
      end
    end
  end

  initial begin : stim
    tx_exp_t    e;
    logic [9:0] fr;
    logic [7:0] drx;
    logic [7:0] dtx;
    logic       stp;
    logic       dotx;

    rst         = 1'b1;
    bus.io_rxd  = 1'b1;
    bus.io_fgi  = 1'b0;
    bus.io_fgo  = 1'b1;
    bus.io_outr = 8'h00;
    ovr_model   = 1'b0;
    ferr_model  = 1'b0;
    repeat (4) @(negedge clk);
    check_reset("in_reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset("after_reset");

    // receive 0x41
    send_rx(8'h41, 1'b1);
    repeat (20) @(negedge clk);
    check("rx41_inpr", 32'(bus.io_inpr), 32'h41);
    check_flags("rx41");
    check("rx41_drain", rx_exp.size(), 0);

    // overrun: core still holding 0x41
    bus.io_fgi = 1'b1;
    send_rx(8'h42, 1'b1);
    repeat (20) @(negedge clk);
    check("ovr_inpr", 32'(bus.io_inpr), 32'h41);
    check_flags("ovr");
    bus.io_fgi = 1'b0;

    // framing error, then a short glitch that must not start a frame
    send_rx(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check_flags("ferr");
    @(negedge clk);
    bus.io_rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.io_rxd = 1'b1;
    $display("rx glitch 4 cycles");
    repeat (200) @(negedge clk);
    check_flags("glitch");
    check("glitch_inpr", 32'(bus.io_inpr), 32'h41);

    // transmit 0xA5
    send_tx(8'hA5);
    repeat (FRAME_CYC + 20) @(negedge clk);
    check("txa5_drain", tx_exp.size(), 0);
    check("txa5_fgoset_count", fgoset_seen, fgoset_exp);

    // re-trigger in the middle of a frame is ignored
    send_tx(8'h3C);
    repeat (50) @(negedge clk);
    bus.io_outr = 8'hFF;
    bus.io_fgo  = 1'b0;
    @(negedge clk);
    bus.io_fgo = 1'b1;
    $display("tx re-trigger mid-frame data=ff");
    repeat (FRAME_CYC + 40) @(negedge clk);
    check("retrig_drain", tx_exp.size(), 0);
    check("retrig_fgoset_count", fgoset_seen, fgoset_exp);

    // randomized concurrent traffic
    for (int n = 0; n < 20; n++) begin
      drx  = 8'($urandom);
      dtx  = 8'($urandom);
      stp  = ($urandom_range(0, 5) != 0);
      dotx = ($urandom_range(0, 1) == 1);
      bus.io_fgi = ($urandom_range(0, 3) == 0);
      fork
        send_rx(drx, stp);
        begin
          if (dotx) send_tx(dtx);
        end
      join
      repeat (30) @(negedge clk);
      check_flags("rand");
      bus.io_fgi = 1'b0;
    end
    check("rand_rx_drain", rx_exp.size(), 0);
    check("rand_tx_drain", tx_exp.size(), 0);

    // reset in the middle of a TX frame (bit 4) and an RX frame (bit 3)
    @(negedge clk);
    bus.io_outr = 8'h96;
    bus.io_fgo  = 1'b0;
    e.data  = 8'h96;
    e.start = cyc + 1;
    tx_exp.push_back(e);
    fr = {1'b1, 8'hC3, 1'b0};
    $display("tx trigger data=96 and rx frame data=c3, to be cut by reset");
    for (int c = 0; c < 70; c++) begin
      if (c % CPB == 0) bus.io_rxd = fr[c / CPB];
      if (c == 1) bus.io_fgo = 1'b1;
      @(negedge clk);
    end
    #2;
    rst        = 1'b1;
    bus.io_rxd = 1'b0;
    #1;
    check_reset("mid_reset");
    ovr_model  = 1'b0;
    ferr_model = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_reset("held_low");
    bus.io_rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_rx(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("post_reset_inpr", 32'(bus.io_inpr), 32'h5A);
    check_flags("post_reset");
    repeat (FRAME_CYC) @(negedge clk);

    check("final_rx_drain", rx_exp.size(), 0);
    check("final_tx_drain", tx_exp.size(), 0);
    check("final_fgoset_count", fgoset_seen, fgoset_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
